// File: rtl/exu_issue_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | exu_issue_ctrl_pkg: instruction bundle layout and shared types             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package exu_issue_ctrl_pkg;

  localparam int DYN_INST_WIDTH = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int NREG           = 32;
  localparam int MAX_INFLIGHT   = 4;
  localparam int CNT_WIDTH      = 32;

  // Bundle layout: [4:0] rd, [9:5] rs1, [14:10] rs2, then use flags; upper bits are payload.
  localparam int RD_LO       = 0;
  localparam int RD_HI       = 4;
  localparam int RS1_LO      = 5;
  localparam int RS1_HI      = 9;
  localparam int RS2_LO      = 10;
  localparam int RS2_HI      = 14;
  localparam int USE_RD_BIT  = 15;
  localparam int USE_RS1_BIT = 16;
  localparam int USE_RS2_BIT = 17;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/exu_issue_ctrl_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | exu_issue_ctrl_scoreboard: busy vector, in-flight count, sticky wb error   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module exu_issue_ctrl_scoreboard
  import exu_issue_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH_P = REG_ADDR_WIDTH,
  parameter int NREG_P           = NREG,
  parameter int MAX_INFLIGHT_P   = MAX_INFLIGHT,
  parameter int INF_W            = $clog2(MAX_INFLIGHT_P + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        set_en_i,
  input  logic [REG_ADDR_WIDTH_P-1:0] set_rd_i,
  input  logic                        wb_en_i,
  input  logic [REG_ADDR_WIDTH_P-1:0] wb_rd_i,
  output logic [NREG_P-1:0]           busy_o,
  output logic [INF_W-1:0]            inflight_o,
  output logic                        wb_err_o
);

  logic [NREG_P-1:0] busy_q, busy_d;
  logic [INF_W-1:0]  inflight_q, inflight_d;
  logic              wb_err_q, wb_err_d;
  logic              set_v, wb_v, wb_hit;

  always_comb begin
    set_v  = set_en_i && (set_rd_i != '0);
    wb_v   = wb_en_i && (wb_rd_i != '0);
    // A writeback colliding with a same-cycle set of that register counts as retiring it.
    wb_hit = wb_v && (busy_q[wb_rd_i] || (set_v && (set_rd_i == wb_rd_i)));

    busy_d = busy_q;
    if (wb_hit) busy_d[wb_rd_i] = 1'b0;
    if (set_v)  busy_d[set_rd_i] = 1'b1;

    inflight_d = inflight_q;
    case ({set_v, wb_hit})
      2'b10:   inflight_d = inflight_q + INF_W'(1);
      2'b01:   inflight_d = inflight_q - INF_W'(1);
      default: inflight_d = inflight_q;
    endcase

    wb_err_d = wb_err_q || (wb_v && !wb_hit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      inflight_q <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign busy_o     = busy_q;
  assign inflight_o = inflight_q;
  assign wb_err_o   = wb_err_q;

endmodule
`default_nettype wire

// File: rtl/exu_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | exu_issue_ctrl: single-entry IDU->EXU issue stage with RAW/WAW interlock   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module exu_issue_ctrl
  import exu_issue_ctrl_pkg::*;
#(
  parameter int MAX_INFLIGHT_P = MAX_INFLIGHT,
  parameter int CNT_WIDTH_P    = CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      idu_valid_i,
  output logic                      idu_ready_o,
  input  logic [DYN_INST_WIDTH-1:0] idu_instr_i,
  output logic                      exu_valid_o,
  input  logic                      exu_ready_i,
  output logic [DYN_INST_WIDTH-1:0] exu_instr_o,
  input  logic                      wb_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_i,
  input  logic                      flush_i,
  output logic [CNT_WIDTH_P-1:0]    stall_cnt_o,
  output logic                      wb_err_o
);

  localparam int INF_W = $clog2(MAX_INFLIGHT_P + 1);

  state_e                    state_q, state_d;
  logic [DYN_INST_WIDTH-1:0] instr_q, instr_d;
  logic [CNT_WIDTH_P-1:0]    stall_q, stall_d;

  logic [NREG-1:0]           busy;
  logic [INF_W-1:0]          inflight;
  logic                      held_vld, hazard, issue, accept;
  logic [REG_ADDR_WIDTH-1:0] rd, rs1, rs2;
  logic                      use_rd, use_rs1, use_rs2;

  assign rd      = instr_q[RD_HI:RD_LO];
  assign rs1     = instr_q[RS1_HI:RS1_LO];
  assign rs2     = instr_q[RS2_HI:RS2_LO];
  assign use_rd  = instr_q[USE_RD_BIT];
  assign use_rs1 = instr_q[USE_RS1_BIT];
  assign use_rs2 = instr_q[USE_RS2_BIT];

  always_comb begin
    held_vld = (state_q == ST_HOLD);
    hazard   = (use_rs1 && (rs1 != '0) && busy[rs1])
             | (use_rs2 && (rs2 != '0) && busy[rs2])
             | (use_rd  && (rd  != '0) && busy[rd])
             | (use_rd  && (inflight == INF_W'(MAX_INFLIGHT_P)));

    exu_valid_o = held_vld && !hazard && !flush_i;
    issue       = exu_valid_o && exu_ready_i;
    // Flush frees the slot, so a new instruction may be captured in the same cycle.
    idu_ready_o = !held_vld || issue || flush_i;
    accept      = idu_valid_i && idu_ready_o;

    state_d = state_q;
    instr_d = instr_q;
    if (accept) begin
      state_d = ST_HOLD;
      instr_d = idu_instr_i;
    end else if (issue || flush_i) begin
      state_d = ST_EMPTY;
    end

    stall_d = stall_q;
    if (held_vld && hazard && !flush_i && !(&stall_q))
      stall_d = stall_q + CNT_WIDTH_P'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      instr_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      stall_q <= stall_d;
    end
  end

  exu_issue_ctrl_scoreboard #(
    .REG_ADDR_WIDTH_P (REG_ADDR_WIDTH),
    .NREG_P           (NREG),
    .MAX_INFLIGHT_P   (MAX_INFLIGHT_P),
    .INF_W            (INF_W)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (issue && use_rd),
    .set_rd_i   (rd),
    .wb_en_i    (wb_en_i),
    .wb_rd_i    (wb_rd_i),
    .busy_o     (busy),
    .inflight_o (inflight),
    .wb_err_o   (wb_err_o)
  );

  assign exu_instr_o = instr_q;
  assign stall_cnt_o = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_exu_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_exu_issue_ctrl: directed scenarios with an issue scoreboard             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_exu_issue_ctrl;
  import exu_issue_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        idu_valid_i, idu_ready_o, exu_valid_o, exu_ready_i;
  logic [31:0] idu_instr_i, exu_instr_o;
  logic        wb_en_i, flush_i, wb_err_o;
  logic [4:0]  wb_rd_i;
  logic [31:0] stall_cnt_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int c0;

  typedef struct {
    logic [31:0] instr;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  exu_issue_ctrl u_dut (
    .clk         (clk),
    .rst         (rst),
    .idu_valid_i (idu_valid_i),
    .idu_ready_o (idu_ready_o),
    .idu_instr_i (idu_instr_i),
    .exu_valid_o (exu_valid_o),
    .exu_ready_i (exu_ready_i),
    .exu_instr_o (exu_instr_o),
    .wb_en_i     (wb_en_i),
    .wb_rd_i     (wb_rd_i),
    .flush_i     (flush_i),
    .stall_cnt_o (stall_cnt_o),
    .wb_err_o    (wb_err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every issue handshake must match the oldest expected issue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && exu_valid_o && exu_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL issue_unexpected: got instr=%h at cyc=%0d, required no issue", exu_instr_o, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.instr !== exu_instr_o || e.cyc != cyc) begin
          failures++;
          $display("FAIL issue: got instr=%h cyc=%0d, required instr=%h cyc=%0d",
                   exu_instr_o, cyc, e.instr, e.cyc);
        end
      end
    end
  end

  function automatic logic [31:0] mk(input logic [13:0] tag, input logic urs2, urs1, urd,
                                     input logic [4:0] rs2, rs1, rd);
    return {tag, urs2, urs1, urd, rs2, rs1, rd};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] instr, input int c);
    exp_t e;
    e.instr = instr;
    e.cyc   = c;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; idu_valid_i = 1'b0; idu_instr_i = '0; exu_ready_i = 1'b1;
    wb_en_i = 1'b0; wb_rd_i = '0; flush_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_exu_valid", exu_valid_o, 0);
    chk("rst_idu_ready", idu_ready_o, 1);
    chk("rst_stall_cnt", stall_cnt_o, 0);
    chk("rst_wb_err", wb_err_o, 0);
  endtask

  logic [31:0] i_a, i_b, i_c;

  initial begin
    do_reset();

    // RAW on x1: addi issues, add stalls two cycles, wb x1 releases it one cycle later.
    i_a = mk(14'd1, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd1);
    i_b = mk(14'd2, 1'b1, 1'b1, 1'b1, 5'd3, 5'd1, 5'd2);
    c0 = cyc;
    idu_valid_i = 1'b1; idu_instr_i = i_a; push(i_a, c0 + 1); tick();
    idu_instr_i = i_b; push(i_b, c0 + 4); tick();
    idu_valid_i = 1'b0; tick();
    wb_en_i = 1'b1; wb_rd_i = 5'd1; tick();
    wb_en_i = 1'b0; tick();
    chk("raw_stall_cnt", stall_cnt_o, 2);

    // In-flight limit: four producers issue, fifth waits for wb x1.
    do_reset();
    c0 = cyc;
    for (int k = 1; k <= 5; k++) begin
      idu_valid_i = 1'b1;
      idu_instr_i = mk(14'(16 + k), 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'(k));
      push(idu_instr_i, (k < 5) ? c0 + k : c0 + 8);
      tick();
    end
    idu_valid_i = 1'b0; tick();
    chk("inflight_limit_valid", exu_valid_o, 0);
    tick();
    wb_en_i = 1'b1; wb_rd_i = 5'd1; tick();
    wb_en_i = 1'b0; tick();
    chk("inflight_stall_cnt", stall_cnt_o, 3);
    chk("inflight_wb_err", wb_err_o, 0);

    // x0 never becomes busy.
    do_reset();
    i_a = mk(14'd32, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
    i_b = mk(14'd33, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    c0 = cyc;
    idu_valid_i = 1'b1; idu_instr_i = i_a; push(i_a, c0 + 1); tick();
    idu_instr_i = i_b; push(i_b, c0 + 2); tick();
    idu_valid_i = 1'b0; tick();
    chk("x0_stall_cnt", stall_cnt_o, 0);
    chk("x0_busy", u_dut.u_sb.busy_q, 0);
    chk("x0_inflight", u_dut.u_sb.inflight_q, 0);

    // EXU backpressure holds the instruction without counting a hazard stall.
    i_a = mk(14'd40, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd11);
    c0 = cyc;
    idu_valid_i = 1'b1; idu_instr_i = i_a; push(i_a, c0 + 2); tick();
    idu_valid_i = 1'b0; exu_ready_i = 1'b0; #1;
    chk("bp_exu_valid", exu_valid_o, 1);
    chk("bp_idu_ready", idu_ready_o, 0);
    tick();
    exu_ready_i = 1'b1; tick();
    chk("bp_stall_cnt", stall_cnt_o, 0);

    // Issue of x7 and wb of x7 in the same cycle.
    do_reset();
    i_a = mk(14'd48, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd7);
    c0 = cyc;
    idu_valid_i = 1'b1; idu_instr_i = i_a; push(i_a, c0 + 1); tick();
    idu_valid_i = 1'b0; wb_en_i = 1'b1; wb_rd_i = 5'd7; tick();
    wb_en_i = 1'b0;
    chk("same_cycle_busy7", u_dut.u_sb.busy_q[7], 1);
    chk("same_cycle_inflight", u_dut.u_sb.inflight_q, 0);

    // Flush of a stalled entry with a simultaneous new instruction.
    do_reset();
    i_a = mk(14'd64, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd4);
    i_b = mk(14'd65, 1'b0, 1'b1, 1'b1, 5'd0, 5'd4, 5'd8);
    i_c = mk(14'd66, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd10);
    c0 = cyc;
    idu_valid_i = 1'b1; idu_instr_i = i_a; push(i_a, c0 + 1); tick();
    idu_instr_i = i_b; tick();
    flush_i = 1'b1; idu_instr_i = i_c; push(i_c, c0 + 3); #1;
    chk("flush_exu_valid", exu_valid_o, 0);
    chk("flush_idu_ready", idu_ready_o, 1);
    tick();
    flush_i = 1'b0; idu_valid_i = 1'b0; tick();
    chk("flush_stall_cnt", stall_cnt_o, 0);
    chk("flush_busy4", u_dut.u_sb.busy_q[4], 1);
    chk("flush_busy8", u_dut.u_sb.busy_q[8], 0);

    // Writeback to a non-busy register is a sticky error; reset clears it.
    do_reset();
    wb_en_i = 1'b1; wb_rd_i = 5'd9; tick();
    wb_en_i = 1'b0;
    chk("wb_err_set", wb_err_o, 1);
    tick(); tick();
    chk("wb_err_sticky", wb_err_o, 1);
    rst = 1'b1; tick();
    rst = 1'b0; #1;
    chk("rst1_exu_valid", exu_valid_o, 0);
    chk("rst1_idu_ready", idu_ready_o, 1);
    chk("rst1_stall_cnt", stall_cnt_o, 0);
    chk("rst1_wb_err", wb_err_o, 0);
    wb_en_i = 1'b1; wb_rd_i = 5'd10; tick();
    wb_en_i = 1'b0;
    chk("late_wb_err", wb_err_o, 1);

    tick(); tick();
    chk("all_expected_issued", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
